// File: rtl/isdu_param.sv
// Instruction sequencer/decoder for the SLC-3 datapath with a parametrised memory wait.
// Outputs are a Moore function of the state; Run/Continue are the only handshakes.
module isdu_param #(
  parameter int MEM_WAIT       = 3,
  parameter bit PAUSE_ON_FETCH = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Fetch_strobe
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  localparam logic [4:0] S_HALTED    = 5'd0;
  localparam logic [4:0] S_FETCH     = 5'd1;
  localparam logic [4:0] S_RD_IR     = 5'd2;
  localparam logic [4:0] S_LOAD_IR   = 5'd3;
  localparam logic [4:0] S_PAUSE_IR1 = 5'd4;
  localparam logic [4:0] S_PAUSE_IR2 = 5'd5;
  localparam logic [4:0] S_DECODE    = 5'd6;
  localparam logic [4:0] S_ADD       = 5'd7;
  localparam logic [4:0] S_AND       = 5'd8;
  localparam logic [4:0] S_NOT       = 5'd9;
  localparam logic [4:0] S_BR_TEST   = 5'd10;
  localparam logic [4:0] S_BR_TAKE   = 5'd11;
  localparam logic [4:0] S_JMP       = 5'd12;
  localparam logic [4:0] S_JSR_LINK  = 5'd13;
  localparam logic [4:0] S_JSR_OFF   = 5'd14;
  localparam logic [4:0] S_JSRR      = 5'd15;
  localparam logic [4:0] S_LDR_ADDR  = 5'd16;
  localparam logic [4:0] S_LDR_RD    = 5'd17;
  localparam logic [4:0] S_LDR_WB    = 5'd18;
  localparam logic [4:0] S_STR_ADDR  = 5'd19;
  localparam logic [4:0] S_STR_DATA  = 5'd20;
  localparam logic [4:0] S_STR_WR    = 5'd21;
  localparam logic [4:0] S_PAUSE_LED = 5'd22;
  localparam logic [4:0] S_PAUSE_W1  = 5'd23;
  localparam logic [4:0] S_PAUSE_W2  = 5'd24;

  logic [4:0]    state;
  logic [4:0]    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          wait_done;

  // One shared counter serves every memory state; it idles at zero elsewhere,
  // so it is already clear on entry to the next memory state.
  assign mem_state = (state == S_RD_IR) || (state == S_LDR_RD) || (state == S_STR_WR);
  assign wait_done = (wait_cnt == CW'(MEM_WAIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_HALTED;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mem_state && !wait_done)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED:    if (Run) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_RD_IR;
      S_RD_IR:     if (wait_done) state_nxt = S_LOAD_IR;
      S_LOAD_IR:   state_nxt = PAUSE_ON_FETCH ? S_PAUSE_IR1 : S_DECODE;
      S_PAUSE_IR1: if (Continue) state_nxt = S_PAUSE_IR2;
      S_PAUSE_IR2: if (!Continue) state_nxt = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'b0001: state_nxt = S_ADD;
          4'b0101: state_nxt = S_AND;
          4'b1001: state_nxt = S_NOT;
          4'b0000: state_nxt = S_BR_TEST;
          4'b1100: state_nxt = S_JMP;
          4'b0100: state_nxt = S_JSR_LINK;
          4'b0110: state_nxt = S_LDR_ADDR;
          4'b0111: state_nxt = S_STR_ADDR;
          4'b1101: state_nxt = S_PAUSE_LED;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR_OFF, S_JSRR, S_LDR_WB:
                   state_nxt = S_FETCH;
      S_BR_TEST:   state_nxt = BEN ? S_BR_TAKE : S_FETCH;
      S_JSR_LINK:  state_nxt = IR_11 ? S_JSR_OFF : S_JSRR;
      S_LDR_ADDR:  state_nxt = S_LDR_RD;
      S_LDR_RD:    if (wait_done) state_nxt = S_LDR_WB;
      S_STR_ADDR:  state_nxt = S_STR_DATA;
      S_STR_DATA:  state_nxt = S_STR_WR;
      S_STR_WR:    if (wait_done) state_nxt = S_FETCH;
      S_PAUSE_LED: state_nxt = S_PAUSE_W1;
      S_PAUSE_W1:  if (Continue) state_nxt = S_PAUSE_W2;
      S_PAUSE_W2:  if (!Continue) state_nxt = S_FETCH;
      default:     state_nxt = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR       = 1'b0;
    LD_MDR       = 1'b0;
    LD_IR        = 1'b0;
    LD_BEN       = 1'b0;
    LD_CC        = 1'b0;
    LD_REG       = 1'b0;
    LD_PC        = 1'b0;
    LD_LED       = 1'b0;
    GatePC       = 1'b0;
    GateMDR      = 1'b0;
    GateALU      = 1'b0;
    GateMARMUX   = 1'b0;
    PCMUX        = 2'b00;
    DRMUX        = 1'b0;
    SR1MUX       = 1'b0;
    SR2MUX       = 1'b0;
    ADDR1MUX     = 1'b0;
    ADDR2MUX     = 2'b00;
    ALUK         = 2'b00;
    Mem_OE       = 1'b0;
    Mem_WE       = 1'b0;
    Fetch_strobe = 1'b0;
    case (state)
      S_FETCH: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_RD_IR, S_LDR_RD: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S_LOAD_IR: begin
        GateMDR      = 1'b1;
        LD_IR        = 1'b1;
        Fetch_strobe = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        SR1MUX  = 1'b1;
        SR2MUX  = (state == S_NOT) ? 1'b0 : IR_5;
        ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_BR_TAKE: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      // JSRR shares the JMP datapath; R7 was already written in JSR_LINK.
      S_JMP, S_JSRR: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S_JSR_LINK: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR_OFF: begin
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S_LDR_ADDR, S_STR_ADDR: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      // Store data passes through the ALU onto the bus; MDR loads from the bus.
      S_STR_DATA: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR_WR:    Mem_WE = 1'b1;
      S_PAUSE_LED: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule
